// File: rtl/risc_mips32_pipe.sv
// risc_mips32_pipe: 5-stage in-order MIPS-like core with a unified word memory and no forwarding or interlocks.
// Latency: an instruction fetched on edge N writes back on edge N+4; throughput is one instruction per cycle.
// Backpressure: none; a taken branch squashes the two younger instructions, and HLT freezes fetch.
module risc_mips32_pipe #(
  parameter int MEM_WORDS = 1024
) (
  input  logic CLK1,
  input  logic RST,
  output logic HALTED
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {T_NOP, T_RR, T_RI, T_LW, T_SW, T_BR, T_HLT} itype_t;

  logic [31:0] MEM      [0:MEM_WORDS-1];
  logic [31:0] REG_FILE [0:31];

  // Fetch state
  logic [31:0] r_pc;
  logic        r_fetch_stop;
  logic        r_halted;
  // IF/ID
  logic [31:0] r_ifid_ir, r_ifid_npc;
  // ID/EX
  itype_t      r_idex_type;
  logic [5:0]  r_idex_op;
  logic [4:0]  r_idex_dst;
  logic [31:0] r_idex_npc, r_idex_a, r_idex_b, r_idex_imm;
  // EX/MEM
  itype_t      r_exmem_type;
  logic [4:0]  r_exmem_dst;
  logic [31:0] r_exmem_alu, r_exmem_b;
  // MEM/WB
  itype_t      r_memwb_type;
  logic [4:0]  r_memwb_dst;
  logic [31:0] r_memwb_alu, r_memwb_lmd;

  // Decode fields of the instruction sitting in IF/ID
  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dst;
  logic [31:0] w_id_imm, w_id_a, w_id_b;
  itype_t      w_id_type;
  logic        w_id_hlt, w_fetch_stop;
  logic        w_wb_we;
  logic [31:0] w_wb_data;
  logic [31:0] w_ex_alu;
  logic        w_ex_taken;

  assign w_id_op  = r_ifid_ir[31:26];
  assign w_id_rs  = r_ifid_ir[25:21];
  assign w_id_rt  = r_ifid_ir[20:16];
  assign w_id_rd  = r_ifid_ir[15:11];
  assign w_id_imm = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};

  // Classify the ID instruction and pick its destination register
  always_comb begin
    w_id_type = T_NOP;
    w_id_dst  = 5'd0;
    case (w_id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        w_id_type = T_RR;
        w_id_dst  = w_id_rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        w_id_type = T_RI;
        w_id_dst  = w_id_rt;
      end
      OP_LW: begin
        w_id_type = T_LW;
        w_id_dst  = w_id_rt;
      end
      OP_SW:            w_id_type = T_SW;
      OP_BNEQZ, OP_BEQZ: w_id_type = T_BR;
      OP_HLT:           w_id_type = T_HLT;
      default:          w_id_type = T_NOP;
    endcase
  end

  // Writeback: R0 writes are dropped so R0 stays zero in the array
  assign w_wb_we   = ((r_memwb_type == T_RR) || (r_memwb_type == T_RI) || (r_memwb_type == T_LW)) &&
                     (r_memwb_dst != 5'd0);
  assign w_wb_data = (r_memwb_type == T_LW) ? r_memwb_lmd : r_memwb_alu;

  // Register read in ID; a same-cycle WB write to the read register bypasses the array
  always_comb begin
    w_id_a = REG_FILE[w_id_rs];
    w_id_b = REG_FILE[w_id_rt];
    if (w_id_rs == 5'd0)                            w_id_a = 32'd0;
    else if (w_wb_we && (r_memwb_dst == w_id_rs))   w_id_a = w_wb_data;
    if (w_id_rt == 5'd0)                            w_id_b = 32'd0;
    else if (w_wb_we && (r_memwb_dst == w_id_rt))   w_id_b = w_wb_data;
  end

  // Execute: ALU result, effective address or branch target, plus branch decision
  always_comb begin
    w_ex_alu   = 32'd0;
    w_ex_taken = 1'b0;
    case (r_idex_type)
      T_RR: begin
        case (r_idex_op)
          OP_ADD:  w_ex_alu = r_idex_a + r_idex_b;
          OP_SUB:  w_ex_alu = r_idex_a - r_idex_b;
          OP_AND:  w_ex_alu = r_idex_a & r_idex_b;
          OP_OR:   w_ex_alu = r_idex_a | r_idex_b;
          OP_SLT:  w_ex_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_b)};
          OP_MUL:  w_ex_alu = r_idex_a * r_idex_b;
          default: w_ex_alu = 32'd0;
        endcase
      end
      T_RI: begin
        case (r_idex_op)
          OP_ADDI: w_ex_alu = r_idex_a + r_idex_imm;
          OP_SUBI: w_ex_alu = r_idex_a - r_idex_imm;
          OP_SLTI: w_ex_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_imm)};
          default: w_ex_alu = 32'd0;
        endcase
      end
      T_LW, T_SW: w_ex_alu = r_idex_a + r_idex_imm;
      T_BR: begin
        w_ex_alu   = r_idex_npc + r_idex_imm;
        w_ex_taken = (r_idex_op == OP_BEQZ) ? (r_idex_a == 32'd0) : (r_idex_a != 32'd0);
      end
      default: w_ex_alu = 32'd0;
    endcase
  end

  // A HLT squashed by an older taken branch must not stop fetch
  assign w_id_hlt     = (w_id_type == T_HLT) && !w_ex_taken;
  assign w_fetch_stop = r_fetch_stop || w_id_hlt;

  // Fetch: redirect on taken branch, feed NOPs once HLT is decoded, else sequential
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      r_pc         <= 32'd0;
      r_ifid_ir    <= 32'd0;
      r_ifid_npc   <= 32'd0;
      r_fetch_stop <= 1'b0;
    end else if (w_ex_taken) begin
      r_pc       <= w_ex_alu;
      r_ifid_ir  <= 32'd0;
      r_ifid_npc <= 32'd0;
    end else if (w_fetch_stop) begin
      r_ifid_ir    <= 32'd0;
      r_ifid_npc   <= 32'd0;
      r_fetch_stop <= 1'b1;
    end else begin
      r_ifid_ir  <= MEM[r_pc[AW-1:0]];
      r_ifid_npc <= r_pc + 32'd1;
      r_pc       <= r_pc + 32'd1;
    end
  end

  // ID/EX register; the ID instruction is squashed when a branch resolves taken
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      r_idex_type <= T_NOP;
      r_idex_op   <= 6'd0;
      r_idex_dst  <= 5'd0;
      r_idex_npc  <= 32'd0;
      r_idex_a    <= 32'd0;
      r_idex_b    <= 32'd0;
      r_idex_imm  <= 32'd0;
    end else begin
      r_idex_type <= w_ex_taken ? T_NOP : w_id_type;
      r_idex_op   <= w_id_op;
      r_idex_dst  <= w_id_dst;
      r_idex_npc  <= r_ifid_npc;
      r_idex_a    <= w_id_a;
      r_idex_b    <= w_id_b;
      r_idex_imm  <= w_id_imm;
    end
  end

  // EX/MEM register
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      r_exmem_type <= T_NOP;
      r_exmem_dst  <= 5'd0;
      r_exmem_alu  <= 32'd0;
      r_exmem_b    <= 32'd0;
    end else begin
      r_exmem_type <= r_idex_type;
      r_exmem_dst  <= r_idex_dst;
      r_exmem_alu  <= w_ex_alu;
      r_exmem_b    <= r_idex_b;
    end
  end

  // MEM/WB register, including the load data read
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      r_memwb_type <= T_NOP;
      r_memwb_dst  <= 5'd0;
      r_memwb_alu  <= 32'd0;
      r_memwb_lmd  <= 32'd0;
    end else begin
      r_memwb_type <= r_exmem_type;
      r_memwb_dst  <= r_exmem_dst;
      r_memwb_alu  <= r_exmem_alu;
      r_memwb_lmd  <= MEM[r_exmem_alu[AW-1:0]];
    end
  end

  // HALTED latches when HLT retires and holds until reset
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST)                        r_halted <= 1'b0;
    else if (r_memwb_type == T_HLT) r_halted <= 1'b1;
  end

  assign HALTED = r_halted;

  // Store in MEM stage; memory contents survive reset
  always @(posedge CLK1) begin
    if (r_exmem_type == T_SW) MEM[r_exmem_alu[AW-1:0]] <= r_exmem_b;
  end

  // Register writeback; register contents survive reset
  always @(posedge CLK1) begin
    if (w_wb_we) REG_FILE[r_memwb_dst] <= w_wb_data;
  end

endmodule

// File: tb/tb_risc_mips32_pipe.sv
// tb_risc_mips32_pipe: directed program checked from a table, cycle-exact halt/reset sequences,
// and random NOP-spaced programs checked against an instruction-level reference interpreter.
module tb_risc_mips32_pipe;
  logic CLK1 = 1'b0;
  logic RST  = 1'b0;
  logic HALTED;

  risc_mips32_pipe #(.MEM_WORDS(1024)) dut (
    .CLK1  (CLK1),
    .RST   (RST),
    .HALTED(HALTED)
  );

  always #5 CLK1 = ~CLK1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [0:1023];
  logic [31:0] m_reg [0:31];

  typedef struct {
    string       name;
    bit          is_mem;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [31:0] v;
    logic [4:0]  s, t;
    v = imm; s = rs[4:0]; t = rt[4:0];
    return {op, s, t, v[15:0]};
  endfunction

  function automatic void add_vec(input string name, input bit is_mem, input int idx, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.is_mem = is_mem; v.idx = idx; v.exp = exp;
    tbl.push_back(v);
  endfunction

  // Hold reset and wipe both arrays
  task automatic clear_all();
    @(negedge CLK1);
    RST = 1'b1;
    for (int i = 0; i < 1024; i++) dut.MEM[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.REG_FILE[i] = 32'd0;
  endtask

  task automatic run_to_halt(input int budget, input string tag);
    int e;
    e = 0;
    @(negedge CLK1);
    RST = 1'b0;
    while (!HALTED && e < budget) begin
      @(posedge CLK1); #1;
      e++;
    end
    checks++;
    if (!HALTED) begin
      errors++;
      $display("FAIL %s halt timeout: HALTED=%b after %0d cycles, required 1", tag, HALTED, e);
    end
    repeat (3) @(posedge CLK1);
    #1;
  endtask

  // Instruction-level reference: sequential semantics, no pipeline
  task automatic model_run();
    int pc;
    logic [31:0] ir, a, b, imm, npc;
    logic [5:0]  op;
    int rs, rt, rd;
    bit done;
    pc = 0; done = 0;
    for (int step = 0; step < 20000 && !done; step++) begin
      ir  = m_mem[pc % 1024];
      op  = ir[31:26];
      rs  = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      a   = (rs == 0) ? 32'd0 : m_reg[rs];
      b   = (rt == 0) ? 32'd0 : m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      npc = pc + 1;
      case (op)
        6'b000000: if (rd != 0) m_reg[rd] = a + b;
        6'b000001: if (rd != 0) m_reg[rd] = a - b;
        6'b000010: if (rd != 0) m_reg[rd] = a & b;
        6'b000011: if (rd != 0) m_reg[rd] = a | b;
        6'b000100: if (rd != 0) m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'b000101: if (rd != 0) m_reg[rd] = a * b;
        6'b001010: if (rt != 0) m_reg[rt] = a + imm;
        6'b001011: if (rt != 0) m_reg[rt] = a - imm;
        6'b001100: if (rt != 0) m_reg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        6'b001000: if (rt != 0) m_reg[rt] = m_mem[(a + imm) & 32'd1023];
        6'b001001: m_mem[(a + imm) & 32'd1023] = b;
        6'b001101: if (a != 0) npc = npc + imm;
        6'b001110: if (a == 0) npc = npc + imm;
        6'b111111: done = 1;
        default: ;
      endcase
      pc = npc;
    end
  endtask

  initial begin
    logic [5:0] rr_ops [6];
    logic [5:0] ri_ops [3];
    rr_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101};
    ri_ops = '{6'b001010, 6'b001011, 6'b001100};

    // ---------------- reset state ----------------
    #2 RST = 1'b1;
    clear_all();
    dut.MEM[0] = enc_i(6'b001010, 1, 0, 7);
    repeat (4) @(posedge CLK1);
    #1;
    chk("reset_halted", {31'd0, HALTED}, 32'd0);
    chk("reset_no_write_R1", dut.REG_FILE[1], 32'd0);

    // ---------------- directed program ----------------
    clear_all();
    dut.MEM[0]  = enc_i(6'b001010, 1, 0, 5);
    dut.MEM[1]  = enc_i(6'b001010, 2, 0, 10);
    dut.MEM[4]  = enc_r(6'b000000, 3, 1, 2);
    dut.MEM[5]  = enc_r(6'b000001, 4, 2, 1);
    dut.MEM[6]  = enc_r(6'b000010, 5, 1, 2);
    dut.MEM[7]  = enc_r(6'b000011, 6, 1, 2);
    dut.MEM[8]  = enc_r(6'b000100, 7, 1, 2);
    dut.MEM[9]  = enc_r(6'b000101, 8, 1, 2);
    dut.MEM[10] = enc_i(6'b001010, 9, 1, 15);
    dut.MEM[11] = enc_i(6'b001011, 10, 2, 3);
    dut.MEM[12] = enc_i(6'b001100, 11, 2, 20);
    dut.MEM[13] = enc_i(6'b001001, 3, 0, 40);
    dut.MEM[14] = enc_i(6'b001010, 1, 0, -1);
    dut.MEM[17] = enc_i(6'b001100, 12, 1, 0);
    dut.MEM[18] = enc_i(6'b001000, 13, 0, 40);
    dut.MEM[21] = enc_r(6'b000000, 14, 13, 0);
    dut.MEM[22] = enc_i(6'b001110, 0, 0, 5);
    for (int i = 23; i <= 27; i++) dut.MEM[i] = enc_i(6'b001010, i - 8, 0, 99);
    dut.MEM[28] = enc_i(6'b001010, 20, 0, 1);
    dut.MEM[29] = enc_i(6'b001101, 0, 2, 2);
    dut.MEM[30] = enc_i(6'b001010, 21, 0, 99);
    dut.MEM[31] = enc_i(6'b001010, 22, 0, 99);
    dut.MEM[32] = enc_i(6'b001101, 0, 0, 3);
    dut.MEM[33] = enc_i(6'b001010, 23, 0, 2);
    dut.MEM[34] = enc_i(6'b001010, 24, 0, 3);
    dut.MEM[35] = enc_i(6'b001010, 0, 0, 7);
    dut.MEM[36] = enc_i(6'b001110, 0, 0, 10);
    dut.MEM[47] = enc_i(6'b001001, 2, 0, 1065);
    dut.MEM[48] = enc_i(6'b001000, 25, 0, 1064);
    dut.MEM[49] = HLT;
    for (int i = 50; i <= 53; i++) dut.MEM[i] = enc_i(6'b001010, i - 24, 0, 1);
    dut.MEM[54] = enc_i(6'b001001, 2, 0, 60);
    run_to_halt(400, "directed");

    add_vec("R0", 0, 0, 32'd0);            add_vec("R1", 0, 1, 32'hFFFF_FFFF);
    add_vec("R3_add", 0, 3, 32'd15);       add_vec("R4_sub", 0, 4, 32'd5);
    add_vec("R5_and", 0, 5, 32'd0);        add_vec("R6_or", 0, 6, 32'd15);
    add_vec("R7_slt", 0, 7, 32'd1);        add_vec("R8_mul", 0, 8, 32'd50);
    add_vec("R9_addi", 0, 9, 32'd20);      add_vec("R10_subi", 0, 10, 32'd7);
    add_vec("R11_slti", 0, 11, 32'd1);     add_vec("R12_slti_neg", 0, 12, 32'd1);
    add_vec("R13_lw", 0, 13, 32'd15);      add_vec("R14_lw_use", 0, 14, 32'd15);
    for (int r = 15; r <= 19; r++) add_vec($sformatf("R%0d_beqz_skip", r), 0, r, 32'd0);
    add_vec("R20_target", 0, 20, 32'd1);   add_vec("R21_bneqz_sq", 0, 21, 32'd0);
    add_vec("R22_bneqz_sq", 0, 22, 32'd0); add_vec("R23_fallthru", 0, 23, 32'd2);
    add_vec("R24_fallthru", 0, 24, 32'd3); add_vec("R25_lw_wrap", 0, 25, 32'd15);
    for (int r = 26; r <= 29; r++) add_vec($sformatf("R%0d_after_hlt", r), 0, r, 32'd0);
    add_vec("MEM40_sw", 1, 40, 32'd15);    add_vec("MEM41_sw_wrap", 1, 41, 32'd10);
    add_vec("MEM60_after_hlt", 1, 60, 32'd0);
    foreach (tbl[i]) begin
      if (tbl[i].is_mem) chk(tbl[i].name, dut.MEM[tbl[i].idx], tbl[i].exp);
      else               chk(tbl[i].name, dut.REG_FILE[tbl[i].idx], tbl[i].exp);
    end
    @(negedge CLK1);
    RST = 1'b1;
    #1;
    chk("halted_cleared_by_reset", {31'd0, HALTED}, 32'd0);

    // ---------------- HALTED timing: HLT at address 2, fetched on edge 3 ----------------
    clear_all();
    dut.MEM[2] = HLT;
    @(negedge CLK1);
    RST = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge CLK1); #1;
      if (e == 6) chk("halted_edge6", {31'd0, HALTED}, 32'd0);
      if (e == 7) chk("halted_edge7", {31'd0, HALTED}, 32'd1);
    end

    // ---------------- reset mid-program ----------------
    clear_all();
    dut.REG_FILE[5] = 32'd100;
    dut.REG_FILE[6] = 32'h55;
    dut.MEM[70]     = 32'hDEAD;
    dut.MEM[0]  = enc_i(6'b001010, 5, 5, 1);
    dut.MEM[3]  = enc_i(6'b001010, 5, 5, 1);
    dut.MEM[4]  = enc_i(6'b001001, 6, 0, 70);
    dut.MEM[6]  = enc_i(6'b001010, 5, 5, 1);
    dut.MEM[9]  = enc_i(6'b001010, 5, 5, 1);
    dut.MEM[12] = HLT;
    @(negedge CLK1);
    RST = 1'b0;
    repeat (7) @(posedge CLK1);
    #1;
    RST = 1'b1;
    #1;
    chk("midrst_halted", {31'd0, HALTED}, 32'd0);
    repeat (2) @(posedge CLK1);
    #1;
    chk("midrst_R5_partial", dut.REG_FILE[5], 32'd101);
    chk("midrst_MEM70_kept", dut.MEM[70], 32'hDEAD);
    chk("midrst_R6_kept", dut.REG_FILE[6], 32'h55);
    @(negedge CLK1);
    RST = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      @(posedge CLK1); #1;
      if (e == 16) chk("restart_halted_edge16", {31'd0, HALTED}, 32'd0);
      if (e == 17) chk("restart_halted_edge17", {31'd0, HALTED}, 32'd1);
    end
    chk("restart_R5", dut.REG_FILE[5], 32'd105);
    chk("restart_MEM70", dut.MEM[70], 32'h55);

    // ---------------- random NOP-spaced programs vs reference ----------------
    for (int p = 0; p < 6; p++) begin
      int n;
      clear_all();
      for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
      m_reg[0] = 32'd0;
      for (int i = 1; i < 32; i++) m_reg[i] = $urandom;
      for (int i = 600; i < 632; i++) m_mem[i] = $urandom;
      n = 30 + $urandom_range(0, 14);
      for (int i = 0; i < n; i++) begin
        int k, pos;
        pos = 3 * i;
        k = $urandom_range(0, 9);
        case (k)
          0, 1, 2: m_mem[pos] = enc_r(rr_ops[$urandom_range(0, 5)], $urandom_range(0, 15),
                                      $urandom_range(0, 15), $urandom_range(0, 15));
          3, 4:    m_mem[pos] = enc_i(ri_ops[$urandom_range(0, 2)], $urandom_range(0, 15),
                                      $urandom_range(0, 15), $urandom);
          5:       m_mem[pos] = enc_i(6'b001000, $urandom_range(0, 15), 0, 600 + $urandom_range(0, 31));
          6:       m_mem[pos] = enc_i(6'b001001, $urandom_range(0, 15), 0, 600 + $urandom_range(0, 31));
          7, 8: begin
            int j;
            j = $urandom_range(i + 1, n);
            m_mem[pos] = enc_i(($urandom_range(0, 1) == 0) ? 6'b001101 : 6'b001110, 0,
                               $urandom_range(0, 15), 3 * j - pos - 1);
          end
          default: m_mem[pos] = enc_i(6'b110000, $urandom_range(1, 15), $urandom_range(0, 15), $urandom);
        endcase
      end
      m_mem[3 * n] = HLT;
      for (int i = 3 * n + 1; i < 3 * n + 4; i++) m_mem[i] = enc_i(6'b001010, 1, 0, 1);
      for (int i = 0; i < 1024; i++) dut.MEM[i] = m_mem[i];
      for (int i = 0; i < 32; i++) dut.REG_FILE[i] = m_reg[i];
      model_run();
      run_to_halt(2000, $sformatf("rand%0d", p));
      for (int i = 0; i < 32; i++) chk($sformatf("rand%0d_R%0d", p, i), dut.REG_FILE[i], m_reg[i]);
      for (int i = 600; i < 632; i++) chk($sformatf("rand%0d_MEM%0d", p, i), dut.MEM[i], m_mem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
